adjust_button_control: RTL
==========================

Name: adjust_button_control

Overview:
- Front end for clock adjustment.
- Synchronizes and debounces the raw MODE and INC push-buttons.
- Runs a mode-selection FSM and drives the adjust_mode / adjust_increment inputs of the adjust-increment stage directly downstream.
- Includes an inactivity timeout that drops out of adjust mode automatically.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable clk cycles required to accept a button level change; legal range ≥1.
- IDLE_TIMEOUT_TICKS, 30: tick strobes with no button activity before returning to IDLE; legal range ≥1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- btn_mode  input  1  raw MODE button, asynchronous, active-high, bouncy.
- btn_inc  input  1  raw INC button, asynchronous, active-high, bouncy.
- tick  input  1  one-clk-wide timebase strobe from prescaler.
- adjust_mode  output  3  one-hot {hours, minutes, seconds}; 3'b000 when not adjusting.
- adjust_increment  output  1  debounced INC level, gated by an active mode.
- adjust_active  output  1  high whenever adjust_mode != 0.
- blink  output  1  field-blink phase for display (see Optional Feature).

Behaviour:
- Interface decision: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state:
  - sync flops = 0, debounced levels = 0, debounce counters = 0
  - FSM = IDLE, timeout counter = IDLE_TIMEOUT_TICKS
  - all outputs = 0
  - Reset asserted mid-press or mid-adjust forces this state immediately. After release, a still-held button counts as a new press only once it has been debounced high (no edge is lost or invented).
- Synchronizer: 2 flops per button.
- Debounce, per button:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - Synchronized value == debounced level → counter cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, the debounced level flips on that edge and the counter clears.
  - A single-cycle glitch shorter than DEBOUNCE_CYCLES never changes the level.
- Edge detect: mode_press = one-cycle pulse on a debounced MODE rising edge. INC rising and falling edges are also detected for the timeout logic.
- Latency: a clean raw MODE edge reaches adjust_mode after DEBOUNCE_CYCLES+3 clk edges (2 sync, DEBOUNCE_CYCLES debounce, 1 FSM register).
- FSM, registered outputs:
  - States: IDLE(000), HOURS(100), MINUTES(010), SECONDS(001).
  - On mode_press: IDLE→HOURS→MINUTES→SECONDS→IDLE (wraps).
  - On timeout expiry in a non-IDLE state: → IDLE.
  - If mode_press and timeout expiry occur in the same cycle, mode_press wins and the timeout counter reloads.
- Timeout counter, width $clog2(IDLE_TIMEOUT_TICKS+1):
  - Reloads to IDLE_TIMEOUT_TICKS on: any debounced edge of either button, debounced INC held high, or state == IDLE.
  - Otherwise decrements on tick.
  - Expiry = tick while counter == 1; counter saturates, never wraps below 0.
- adjust_increment = debounced INC AND state != IDLE. Combinational from registers, no extra latency.
  - INC held through a mode change stays asserted; the downstream stage handles the restart.
  - INC held while entering IDLE deasserts adjust_increment in the same cycle adjust_mode goes 000.
- adjust_active = |adjust_mode.
- Both debounced levels change in the same cycle: each is handled independently, with no priority interaction.

Optional Feature:
- Macro ADJUST_BLINK_EN.
- Defined:
  - blink toggles on each tick while state != IDLE and debounced INC is low.
  - blink is forced 1 while INC is held, so the field stays visible during increments.
  - blink is cleared to 0 on any state change and in IDLE.
- Undefined: blink tied to constant 0; no toggle register synthesized.

Test Plan (DEBOUNCE_CYCLES=4, IDLE_TIMEOUT_TICKS=3 unless noted):
- Reset, then a clean btn_mode pulse of 10 cycles → adjust_mode 000→100 exactly 7 clk edges after the rising edge is first sampled; adjust_active=1.
- btn_mode bouncing 1-0-1-0 with 2-cycle pulses, then stable high → exactly one FSM advance. Four clean presses → 100, 010, 001, 000.
- In MINUTES, hold btn_inc for 20 cycles → adjust_increment rises 6 cycles after the raw edge, stays high, falls 6 cycles after release. In IDLE the same stimulus → adjust_increment stays 0.
- In HOURS with no activity, 3 tick strobes → adjust_mode=000 on the third tick edge. Repeat with a debounced mode_press coincident with the third tick → adjust_mode=010, timeout counter reloaded to 3.
- In SECONDS, deassert rst_n asynchronously mid-cycle with btn_inc held → all outputs 0 immediately. After release, adjust_increment stays 0 because the state is IDLE.
- With ADJUST_BLINK_EN: in HOURS, 4 ticks, INC low → blink 1,0,1,0. Press INC → blink=1. Without the macro, blink=0 throughout.

Source files
------------

// File: rtl/adjust_button_control.sv
// Clock-adjust front end: MODE/INC button sync + debounce, mode FSM, inactivity timeout.
// Optional field-blink output is built only when ADJUST_BLINK_EN is defined.
module adjust_button_control #(
  parameter int DEBOUNCE_CYCLES    = 16,
  parameter int IDLE_TIMEOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       tick,
  output logic [2:0] adjust_mode,
  output logic       adjust_increment,
  output logic       adjust_active,
  output logic       blink
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TOW = $clog2(IDLE_TIMEOUT_TICKS + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TOW-1:0] TO_LOAD = TOW'(IDLE_TIMEOUT_TICKS);
  localparam logic [TOW-1:0] TO_ONE  = TOW'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    HOURS   = 3'b100,
    MINUTES = 3'b010,
    SECONDS = 3'b001
  } state_t;

  // Bit 0 carries MODE, bit 1 carries INC throughout.
  logic [1:0]          sync1, sync2;
  logic [1:0]          db, db_q;
  logic [1:0][DBW-1:0] db_cnt;
  logic [TOW-1:0]      to_cnt;
  state_t              state, state_n;

  logic mode_press, any_edge, reload, expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_q   <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= {btn_inc, btn_mode};
      sync2 <= sync1;
      db_q  <= db;
      // The level flips on the edge where the mismatch count would reach DEBOUNCE_CYCLES.
      for (int unsigned b = 0; b < 2; b++) begin
        if (sync2[b] == db[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          db[b]     <= ~db[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end
    end
  end

  assign mode_press = db[0] & ~db_q[0];
  assign any_edge   = |(db ^ db_q);
  assign reload     = any_edge | db[1] | (state == IDLE);
  assign expire     = tick & ~reload & (to_cnt == TO_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= TO_LOAD;
    end else if (reload) begin
      to_cnt <= TO_LOAD;
    end else if (tick && (to_cnt != '0)) begin
      to_cnt <= to_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (mode_press) begin
      case (state)
        IDLE:    state_n = HOURS;
        HOURS:   state_n = MINUTES;
        MINUTES: state_n = SECONDS;
        SECONDS: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end else if (expire) begin
      state_n = IDLE;
    end
  end

  assign adjust_mode      = state;
  assign adjust_active    = |state;
  assign adjust_increment = db[1] & (state != IDLE);

`ifdef ADJUST_BLINK_EN
  logic blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= 1'b0;
    end else if ((state_n != state) || (state_n == IDLE)) begin
      blink_q <= 1'b0;
    end else if (tick && !db[1]) begin
      blink_q <= ~blink_q;
    end
  end

  // Held INC overrides the phase so the field stays lit while incrementing.
  assign blink = (state != IDLE) & (db[1] | blink_q);
`else
  assign blink = 1'b0;
`endif

endmodule
